// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: memory-stage <-> data-memory controller bus.
//   master : memory stage (drives request/we_re/mask/address/store_data)
//   slave  : data_mem_ctrl (drives load_data/data_valid/stall/access_fault)
// Params: DataWidth - data/address width.
interface data_mem_ctrl_if #(
  parameter int DataWidth = 32
);
  logic                 request;
  logic                 we_re;
  logic [3:0]           mask;
  logic [DataWidth-1:0] address;
  logic [DataWidth-1:0] store_data;
  logic [DataWidth-1:0] load_data;
  logic                 data_valid;
  logic                 stall;
  logic                 access_fault;

  modport master (
    output request, we_re, mask, address, store_data,
    input  load_data, data_valid, stall, access_fault
  );

  modport slave (
    input  request, we_re, mask, address, store_data,
    output load_data, data_valid, stall, access_fault
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: fixed-latency data-memory controller behind the RV32I
// memory stage. Accepts one access in IDLE, waits Latency cycles, then
// performs the RAM write/read on the edge entering RESP and pulses
// data_valid for the single RESP cycle.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - data_mem_ctrl_if.slave (request/we_re/mask/address/store_data in,
//           load_data/data_valid/stall/access_fault out)
// Params: DataWidth (32), Depth (words, power of two >= 2), Latency (>= 1).
// Build option: define DMEM_BOUNDS_CHECK_EN to flag addresses >= Depth*4 as
// faulting (no write, load returns 0, access_fault pulses with data_valid).
// Without it addresses wrap modulo Depth*4 and access_fault is tied 0.
module data_mem_ctrl #(
  parameter int DataWidth = 32,
  parameter int Depth     = 1024,
  parameter int Latency   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  data_mem_ctrl_if.slave bus
);

  localparam int IdxW = $clog2(Depth);
  // Counter only ever holds values 0..Latency-1.
  localparam int CntW = (Latency > 1) ? $clog2(Latency) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(Latency - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  // Holding registers for the accepted access.
  logic                 we_q;
  logic [3:0]           mask_q;
  logic [DataWidth-1:0] data_q;
  logic [IdxW-1:0]      idx_q;
  logic                 fault_q;

  logic [DataWidth-1:0] load_q;
  logic [DataWidth-1:0] ram [Depth];

  logic                 accept;
  logic                 resp_entry;
  logic                 addr_fault;
  logic                 unused_addr_lo;

  assign unused_addr_lo = ^bus.address[1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign addr_fault = (bus.address >> (IdxW + 2)) != '0;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.address[DataWidth-1:IdxW+2];
  assign addr_fault     = 1'b0;
`endif

  assign accept = (state_q == IDLE) && bus.request;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.request) begin
          cnt_d   = CntInit;
          state_d = (Latency > 1) ? BUSY : RESP;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        // <= rather than == so a corrupted zero count cannot hang here.
        if (cnt_q <= CntW'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign resp_entry = (state_q != RESP) && (state_d == RESP);

  // ---------------- capture ----------------
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.we_re;
      mask_q  <= bus.mask;
      data_q  <= bus.store_data;
      idx_q   <= bus.address[IdxW+1:2];
      fault_q <= addr_fault;
    end
  end

  // With Latency==1 the RESP-entry edge is the acceptance edge itself, so
  // the access must come straight from the bus rather than the holding
  // registers, which are only being loaded on that same edge.
  logic                 idle_path;
  logic                 eff_we;
  logic [3:0]           eff_mask;
  logic [DataWidth-1:0] eff_data;
  logic [IdxW-1:0]      eff_idx;
  logic                 eff_fault;

  assign idle_path = (state_q == IDLE);
  assign eff_we    = idle_path ? bus.we_re                : we_q;
  assign eff_mask  = idle_path ? bus.mask                 : mask_q;
  assign eff_data  = idle_path ? bus.store_data           : data_q;
  assign eff_idx   = idle_path ? bus.address[IdxW+1:2]    : idx_q;
  assign eff_fault = idle_path ? addr_fault               : fault_q;

  // ---------------- RAM ----------------
  // Not reset; rst_n only gates the write so an access aborted on its
  // completion edge leaves memory untouched.
  always_ff @(posedge clk) begin
    if (rst_n && resp_entry && eff_we && !eff_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (eff_mask[b]) ram[eff_idx][8*b +: 8] <= eff_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_q <= '0;
    end else if (resp_entry && !eff_we) begin
      load_q <= eff_fault ? '0 : ram[eff_idx];
    end
  end

  // ---------------- outputs ----------------
  assign bus.load_data  = load_q;
  assign bus.data_valid = (state_q == RESP);
  assign bus.stall      = bus.request & ~bus.data_valid;
`ifdef DMEM_BOUNDS_CHECK_EN
  assign bus.access_fault = (state_q == RESP) && fault_q;
`else
  assign bus.access_fault = 1'b0;
`endif

endmodule
